// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: inferred SDP RAM with registered read
// feeding a 2-entry skid stage, plus level, almost flags, flush and sticky overflow.
module ipml_sync_prefetch_fifo_v2_0 #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH_W  = 10,
  parameter int unsigned AF_LEVEL = (1 << DEPTH_W) - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DEPTH_W:0]    level,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  input  logic                err_clr
);

  localparam int unsigned      CAP      = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] AF_L     = (DEPTH_W+1)'(AF_LEVEL);
  localparam logic [DEPTH_W:0] AE_L     = (DEPTH_W+1)'(AE_LEVEL);
  localparam logic [DEPTH_W:0] CNT_ONE  = {{DEPTH_W{1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] PTR_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]  mem [CAP];
  logic [DATA_W-1:0]  ram_q;
  logic [DATA_W-1:0]  skid0;
  logic [DATA_W-1:0]  skid1;
  logic [DEPTH_W-1:0] wr_ptr;
  logic [DEPTH_W-1:0] rd_ptr;
  logic [DEPTH_W:0]   ram_cnt;
  logic [DEPTH_W:0]   level_q;
  logic [1:0]         skid_cnt;
  logic               rd_pend;
  logic               wr;
  logic               pop;
  logic               rd_en;

  assign in_ready     = ~level_q[DEPTH_W];
  assign out_valid    = (skid_cnt != 2'd0);
  assign out_data     = skid0;
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);

  assign wr  = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  // Skid entries plus the read in flight never exceed two; a pop frees a slot this edge.
  assign rd_en = (ram_cnt != '0) && (((skid_cnt + {1'b0, rd_pend}) != 2'd2) || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in_data;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      level_q  <= '0;
      rd_pend  <= 1'b0;
      skid_cnt <= '0;
      skid0    <= '0;
      skid1    <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) overflow <= 1'b1;
      else if (err_clr)          overflow <= 1'b0;

      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        ram_cnt  <= '0;
        level_q  <= '0;
        rd_pend  <= 1'b0;
        skid_cnt <= '0;
      end else begin
        if (wr)    wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
        rd_pend <= rd_en;

        case ({wr, rd_en})
          2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
          2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
          default: ;
        endcase

        case ({wr, pop})
          2'b10:   level_q <= level_q + CNT_ONE;
          2'b01:   level_q <= level_q - CNT_ONE;
          default: ;
        endcase

        // Returning RAM word lands in the first free slot after any pop shift.
        case ({rd_pend, pop})
          2'b11: begin
            if (skid_cnt == 2'd1) begin
              skid0 <= ram_q;
            end else begin
              skid0 <= skid1;
              skid1 <= ram_q;
            end
          end
          2'b01: begin
            skid0    <= skid1;
            skid_cnt <= skid_cnt - 2'd1;
          end
          2'b10: begin
            if (skid_cnt == 2'd0) skid0 <= ram_q;
            else                  skid1 <= ram_q;
            skid_cnt <= skid_cnt + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// Randomised bench for ipml_sync_prefetch_fifo_v2_0 against a queue-based model
// (entry becomes visible two edges after its write), plus directed literal checks.
module tb_ipml_sync_prefetch_fifo_v2_0;

  localparam int CAP = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] level;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  ipml_sync_prefetch_fifo_v2_0 #(
    .DATA_W(8), .DEPTH_W(3), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: ordered list of held words with the edge index of their write.
  typedef struct { logic [7:0] d; int t; } ent_t;
  ent_t mq[$];
  int   now = 0;
  bit   m_ok = 0;
  bit   m_ovf = 0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (mq[0].t + 3 <= now);
  endfunction

  always @(posedge clk) begin
    bit full, vld;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0;
      m_ok  = 1;
    end else if (m_ok) begin
      full = (mq.size() == CAP);
      vld  = m_valid();
      if (in_valid && full) m_ovf = 1;
      else if (err_clr)     m_ovf = 0;
      if (flush) mq.delete();
      else begin
        if (vld && out_ready) void'(mq.pop_front());
        if (in_valid && !full) mq.push_back('{d: in_data, t: now});
      end
    end
    now++;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("level", level, mq.size());
      chk("in_ready", in_ready, mq.size() < CAP);
      chk("out_valid", out_valid, m_valid());
      if (m_valid()) chk("out_data", out_data, mq[0].d);
      chk("almost_full", almost_full, mq.size() >= 6);
      chk("almost_empty", almost_empty, mq.size() <= 1);
      chk("overflow", overflow, m_ovf);
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 10) begin
      step();
      n++;
    end
    if (!out_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_rd;
    int pops;

    step();
    do_reset();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_almost_empty", almost_empty, 1);

    // 1: single write latency
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_level_e1", level, 1);
    chk("t1_valid_e1", out_valid, 0);
    step();
    chk("t1_valid_e2", out_valid, 0);
    step();
    chk("t1_valid_e3", out_valid, 1);
    chk("t1_data_e3", out_data, 8'hA5);
    chk("t1_ae", almost_empty, 1);

    // 2: fill, overflow, drain in order
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      step();
      if (i == 4) chk("t2_af_at5", almost_full, 0);
      if (i == 5) chk("t2_af_at6", almost_full, 1);
    end
    chk("t2_level_full", level, 8);
    chk("t2_in_ready_full", in_ready, 0);
    in_data = 8'hEE;
    step();
    chk("t2_overflow", overflow, 1);
    chk("t2_level_after_ovf", level, 8);
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_valid();
      chk("t2_pop_order", out_data, 8'(i));
      step();
    end
    out_ready = 1'b0;
    chk("t2_drained", level, 0);

    // 3: full, then continuous write+pop across pointer wraps
    v = 8'h10;
    for (int i = 0; i < 8; i++) begin
      in_data = v; in_valid = 1'b1;
      step();
      v++;
    end
    exp_rd = 8'h10; pops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_data = v;
      if (out_valid) begin
        chk("t3_stream", out_data, exp_rd);
        exp_rd++;
        pops++;
      end
      if (in_ready) v++;
      step();
    end
    chk("t3_pops", pops, 40);
    in_valid = 1'b0; out_ready = 1'b0;

    // 4: flush with simultaneous write and pop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h50 + i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t4_level5", level, 5);
    chk("t4_valid", out_valid, 1);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 8'h77;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_flush_level", level, 0);
    chk("t4_flush_valid", out_valid, 0);
    chk("t4_flush_ready", in_ready, 1);
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("t4_3c_not_yet", out_valid, 0);
    step();
    chk("t4_3c_valid", out_valid, 1);
    chk("t4_3c_data", out_data, 8'h3C);

    // 5: stalled head stays constant while filling
    for (int i = 0; i < 10; i++) begin
      in_data = 8'($urandom); in_valid = 1'b1;
      step();
      chk("t5_hold", out_data, 8'h3C);
    end
    in_valid = 1'b0;
    chk("t5_level", level, 8);

    // 6: reset mid-traffic, overflow clear and set/clear collision
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
      step();
    end
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_level", level, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_data", out_data, 8'h00);
    chk("t6_ready", in_ready, 1);
    chk("t6_af", almost_full, 0);
    chk("t6_ae", almost_empty, 1);
    chk("t6_ovf", overflow, 0);
    for (int i = 0; i < 9; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      step();
    end
    chk("t6_ovf_set", overflow, 1);
    in_valid = 1'b0; err_clr = 1'b1;
    step();
    chk("t6_ovf_clr", overflow, 0);
    in_valid = 1'b1;
    step();
    chk("t6_set_wins", overflow, 1);
    in_valid = 1'b0; err_clr = 1'b0;

    // Random traffic with varying bias, rare flush/reset/err_clr
    for (int i = 0; i < 3000; i++) begin
      int wb, rb;
      wb = ((i / 200) % 2 == 0) ? 70 : 35;
      rb = ((i / 200) % 2 == 0) ? 35 : 70;
      in_data   = 8'($urandom);
      in_valid  = ($urandom_range(0, 99) < wb);
      out_ready = ($urandom_range(0, 99) < rb);
      flush     = ($urandom_range(0, 59) == 0);
      err_clr   = ($urandom_range(0, 19) == 0);
      rst_n     = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
